me_loader: RTL and testbench

Host-side front end for the motion-estimation core. It takes a byte stream (template block followed by search window) and writes it into the template-block and search-window memories through their write ports. It then runs the level-sensitive req/ack exchange with the ME core and latches min_sad and min_mvec for the host. It is the writer/initiator counterpart of the core, which only reads those memories and responds to req.

---
 rtl/me_loader.sv | 140 ++++++++++++++
 tb/tb_me_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/me_loader.sv
// Host-side loader for the motion-estimation core: streams template block and
// search window into their memories, then runs the req/ack exchange and latches the result.
module me_loader #(
  parameter int TB_PELS = 256,
  parameter int SW_PELS = 4096,
  parameter int TB_AW   = 8,
  parameter int SW_AW   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              tb_we,
  output logic [TB_AW-1:0]  tb_waddr,
  output logic [7:0]        tb_wdata,
  output logic              sw_we,
  output logic [SW_AW-1:0]  sw_waddr,
  output logic [7:0]        sw_wdata,
  output logic              req,
  input  logic              ack,
  input  logic [15:0]       min_sad,
  input  logic [11:0]       min_mvec,
  output logic [15:0]       res_sad,
  output logic [11:0]       res_mvec,
  output logic              done,
  output logic              busy
);

  localparam int CW = (TB_AW > SW_AW) ? TB_AW : SW_AW;

  typedef enum logic [2:0] {IDLE, LOAD_TB, LOAD_SW, REQ, REL} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept;
  logic              tb_we_q, sw_we_q, done_q;
  logic [TB_AW-1:0]  tb_waddr_q;
  logic [SW_AW-1:0]  sw_waddr_q;
  logic [7:0]        tb_wdata_q, sw_wdata_q;
  logic [15:0]       res_sad_q;
  logic [11:0]       res_mvec_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_ready = 1'b0;
    req     = 1'b0;
    accept  = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_TB;
          cnt_d   = '0;
        end
      end
      LOAD_TB: begin
        s_ready = 1'b1;
        accept  = s_valid;
        if (s_valid) begin
          // Terminal count forces the state change, so the counter never wraps.
          if (cnt_q == CW'(TB_PELS - 1)) begin
            state_d = LOAD_SW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_SW: begin
        s_ready = 1'b1;
        accept  = s_valid;
        if (s_valid) begin
          if (cnt_q == CW'(SW_PELS - 1)) begin
            state_d = REQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (ack) state_d = REL;
      end
      REL: begin
        if (!ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tb_we_q    <= 1'b0;
      sw_we_q    <= 1'b0;
      tb_waddr_q <= '0;
      sw_waddr_q <= '0;
      tb_wdata_q <= '0;
      sw_wdata_q <= '0;
      done_q     <= 1'b0;
      res_sad_q  <= '0;
      res_mvec_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tb_we_q <= accept && (state_q == LOAD_TB);
      sw_we_q <= accept && (state_q == LOAD_SW);
      if (accept && (state_q == LOAD_TB)) begin
        tb_waddr_q <= cnt_q[TB_AW-1:0];
        tb_wdata_q <= s_data;
      end
      if (accept && (state_q == LOAD_SW)) begin
        sw_waddr_q <= cnt_q[SW_AW-1:0];
        sw_wdata_q <= s_data;
      end
      // Result is captured only on the REQ->REL edge; ack elsewhere is ignored.
      done_q <= (state_q == REQ) && ack;
      if ((state_q == REQ) && ack) begin
        res_sad_q  <= min_sad;
        res_mvec_q <= min_mvec;
      end
    end
  end

  assign tb_we    = tb_we_q;
  assign tb_waddr = tb_waddr_q;
  assign tb_wdata = tb_wdata_q;
  assign sw_we    = sw_we_q;
  assign sw_waddr = sw_waddr_q;
  assign sw_wdata = sw_wdata_q;
  assign done     = done_q;
  assign res_sad  = res_sad_q;
  assign res_mvec = res_mvec_q;

endmodule

// File: tb/tb_me_loader.sv
// Directed bench for me_loader: scoreboard of expected memory writes plus
// handshake, latency, reset and ignored-event checks.
module tb_me_loader;

  localparam int TBP = 256;
  localparam int SWP = 4096;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, ack;
  logic [7:0]  s_data;
  logic [15:0] min_sad;
  logic [11:0] min_mvec;
  logic        s_ready, tb_we, sw_we, req, done, busy;
  logic [7:0]  tb_waddr, tb_wdata, sw_wdata;
  logic [11:0] sw_waddr, res_mvec;
  logic [15:0] res_sad;

  me_loader dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .tb_we(tb_we), .tb_waddr(tb_waddr), .tb_wdata(tb_wdata),
    .sw_we(sw_we), .sw_waddr(sw_waddr), .sw_wdata(sw_wdata), .req(req), .ack(ack),
    .min_sad(min_sad), .min_mvec(min_mvec), .res_sad(res_sad), .res_mvec(res_mvec),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {bit sel; int addr; int data;} wr_t;
  wr_t wq[$];
  wr_t cur;
  bit  acc_this = 1'b0;
  bit  exp_we   = 1'b0;
  bit  mon_en   = 1'b0;
  int  cyc      = 0;
  int  start_cyc = 0;
  int  done_cnt = 0;
  int  n_chk    = 0;
  int  n_pass   = 0;
  logic [15:0] exp_sad  = '0;
  logic [11:0] exp_mvec = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Expected writes are queued when the bench drives an accepted byte.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    exp_we <= acc_this && !rst;
    if (acc_this && !rst) wq.push_back(cur);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e;
      chk("we_expected", {31'd0, tb_we | sw_we}, {31'd0, exp_we});
      chk("we_exclusive", {31'd0, tb_we & sw_we}, 32'd0);
      if (tb_we | sw_we) begin
        if (wq.size() == 0) begin
          chk("write_extra", 32'(wq.size()), 32'd1);
        end else begin
          e = wq.pop_front();
          chk("wr_sel", {31'd0, sw_we}, {31'd0, e.sel});
          if (e.sel) begin
            chk("sw_waddr", 32'(sw_waddr), 32'(e.addr));
            chk("sw_wdata", 32'(sw_wdata), 32'(e.data));
          end else begin
            chk("tb_waddr", 32'(tb_waddr), 32'(e.addr));
            chk("tb_wdata", 32'(tb_wdata), 32'(e.data));
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_sready", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic load(input bit do_start, input bit bp, input int limit, input bit inj);
    int  k = 0;
    int  guard = 0;
    bit  v;
    bit  did_start = 1'b0;
    bit  did_ack = 1'b0;
    int  done_base;
    done_base = done_cnt;
    if (do_start) pulse_start();
    while (k < limit && guard < 20000) begin
      v = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cur.sel  = (k >= TBP);
      cur.addr = cur.sel ? k - TBP : k;
      cur.data = cur.addr % 256;
      s_valid  = v;
      s_data   = 8'(cur.data);
      acc_this = v;
      chk("load_sready", {31'd0, s_ready}, 32'd1);
      start = 1'b0;
      ack   = 1'b0;
      if (inj && !did_start && k == 10) begin
        start = 1'b1;
        did_start = 1'b1;
      end
      if (inj && !did_ack && k == TBP + 100) begin
        ack = 1'b1;
        min_sad  = 16'hDEAD;
        min_mvec = 12'hBAD;
        did_ack = 1'b1;
      end
      step();
      if (v) k++;
      guard++;
    end
    s_valid  = 1'b0;
    acc_this = 1'b0;
    start    = 1'b0;
    ack      = 1'b0;
    chk("load_bytes", 32'(k), 32'(limit));
    if (inj) begin
      chk("spurious_res_sad", 32'(res_sad), 32'(exp_sad));
      chk("spurious_res_mvec", 32'(res_mvec), 32'(exp_mvec));
      chk("spurious_done", 32'(done_cnt - done_base), 32'd0);
    end
  endtask

  task automatic handshake(input logic [15:0] sad, input logic [11:0] mvec,
                           input bit ign_start, input bit b2b, input bit chk_lat);
    int g = 0;
    int done_base;
    done_base = done_cnt;
    while (!req && g < 100) begin
      step();
      g++;
    end
    chk("req_seen", {31'd0, req}, 32'd1);
    if (chk_lat) chk("req_latency", 32'(cyc - start_cyc), 32'd4353);
    for (int i = 0; i < 20; i++) begin
      start = (ign_start && i == 5);
      step();
    end
    start = 1'b0;
    chk("req_held", {31'd0, req}, 32'd1);
    ack = 1'b1;
    min_sad  = sad;
    min_mvec = mvec;
    step();
    exp_sad  = sad;
    exp_mvec = mvec;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("req_drop", {31'd0, req}, 32'd0);
    chk("res_sad", 32'(res_sad), 32'(sad));
    chk("res_mvec", 32'(res_mvec), 32'(mvec));
    min_sad  = ~sad;
    min_mvec = ~mvec;
    step();
    chk("done_once", {31'd0, done}, 32'd0);
    chk("res_sad_hold", 32'(res_sad), 32'(sad));
    start = ign_start;
    step();
    start = 1'b0;
    step();
    chk("busy_rel", {31'd0, busy}, 32'd1);
    chk("req_rel", {31'd0, req}, 32'd0);
    ack = 1'b0;
    chk("busy_ack_fall", {31'd0, busy}, 32'd1);
    step();
    chk("busy_low", {31'd0, busy}, 32'd0);
    chk("done_count", 32'(done_cnt - done_base), 32'd1);
    if (b2b) begin
      pulse_start();
    end else begin
      step();
      chk("idle_stays", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    ack = 1'b0; min_sad = '0; min_mvec = '0;
    repeat (3) step();
    chk("rst_sready", {31'd0, s_ready}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_res_sad", 32'(res_sad), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Full-rate run with ignored start/ack events.
    load(1'b1, 1'b0, TBP + SWP, 1'b1);
    handshake(16'h01A3, 12'h3F1, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of the search-window load.
    load(1'b1, 1'b1, TBP + 50, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_sad = '0;
    exp_mvec = '0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_sready", {31'd0, s_ready}, 32'd0);
    chk("mid_rst_we", {30'd0, tb_we, sw_we}, 32'd0);
    chk("mid_rst_addr", {12'd0, tb_waddr, sw_waddr}, 32'd0);
    chk("mid_rst_data", {16'd0, tb_wdata, sw_wdata}, 32'd0);
    chk("mid_rst_res", {4'd0, res_sad, res_mvec}, 32'd0);
    chk("mid_rst_done_req", {30'd0, done, req}, 32'd0);

    // Backpressured run, then back-to-back full-rate run.
    load(1'b1, 1'b1, TBP + SWP, 1'b0);
    handshake(16'h5A5A, 12'h0C3, 1'b0, 1'b1, 1'b0);
    load(1'b0, 1'b0, TBP + SWP, 1'b0);
    handshake(16'h0BEE, 12'h123, 1'b0, 1'b0, 1'b1);

    repeat (2) step();
    chk("queue_empty", 32'(wq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, observed cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
